// File: rtl/tail_deframer_if.sv
// Handshake bundle for the tail deframer: upstream packed bytes in,
// unpacked elements plus frame status pulses out.
interface tail_deframer_if #(
    parameter int BusWidth      = 8,
    parameter int UnpackedWidth = 1
);
    logic                     valid_i;
    logic                     ready_o;
    logic [BusWidth-1:0]      data_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [UnpackedWidth-1:0] unpacked_o;
    logic                     last_o;
    logic                     frame_ok_o;
    logic                     frame_err_o;

    // Deframer side
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, unpacked_o, last_o, frame_ok_o, frame_err_o
    );

    // Source/sink side (byte producer and element consumer)
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, unpacked_o, last_o, frame_ok_o, frame_err_o
    );
endinterface

// File: rtl/tail_deframer.sv
// Tail deframer: unpacks bus bytes into elements for one frame payload,
// then checks a two-byte tail, hunting for the tail pattern on mismatch.
module tail_deframer #(
    parameter int         UnpackedWidth  = 1,
    parameter int         PackedNum      = 8,
    parameter int         PacketLenElems = 75644,
    parameter logic [7:0] TailByte0      = 8'hA5,
    parameter logic [7:0] TailByte1      = 8'h5A
) (
    input logic           clk_i,
    input logic           rst_ni,
    tail_deframer_if.slave bus
);

    localparam int BusWidth     = UnpackedWidth * PackedNum;
    localparam int PayloadBytes = (PacketLenElems + PackedNum - 1) / PackedNum;
    localparam int ElemW        = (PacketLenElems > 1) ? $clog2(PacketLenElems) : 1;
    localparam int SubW         = (PackedNum > 1) ? $clog2(PackedNum) : 1;

    localparam logic [ElemW-1:0]    ElemLast = ElemW'(PacketLenElems - 1);
    localparam logic [SubW-1:0]     SubLast  = SubW'(PackedNum - 1);
    localparam logic [BusWidth-1:0] Tail0    = BusWidth'(TailByte0);
    localparam logic [BusWidth-1:0] Tail1    = BusWidth'(TailByte1);

    typedef enum logic [2:0] {
        PAYLOAD,
        TAIL0,
        TAIL1,
        HUNT0,
        HUNT1
    } state_e;

    state_e state_q, state_d;
    logic   ok_q, ok_d;
    logic   err_q, err_d;

    logic [PackedNum-1:0][UnpackedWidth-1:0] hold_q;
    logic                                    hold_valid_q;
    logic [SubW-1:0]                         sub_q;
    logic [ElemW-1:0]                        elem_q;

    logic in_payload;
    logic byte_hs;
    logic elem_hs;
    logic elem_at_last;

    assign in_payload   = (state_q == PAYLOAD);
    assign elem_at_last = (elem_q == ElemLast);

    assign bus.ready_o     = in_payload ? !hold_valid_q : 1'b1;
    assign bus.valid_o     = in_payload && hold_valid_q;
    assign bus.unpacked_o  = bus.valid_o ? hold_q[sub_q] : '0;
    assign bus.last_o      = bus.valid_o && elem_at_last;
    assign bus.frame_ok_o  = ok_q;
    assign bus.frame_err_o = err_q;

    assign byte_hs = bus.valid_i && bus.ready_o;
    assign elem_hs = bus.valid_o && bus.ready_i;

    // State register and registered status pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PAYLOAD;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Next-state: leave payload on the final element, then tail check / hunt
    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            PAYLOAD: begin
                if (elem_hs && elem_at_last) state_d = TAIL0;
            end
            TAIL0: begin
                if (byte_hs) begin
                    if (bus.data_i == Tail0) begin
                        state_d = TAIL1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT0;
                    end
                end
            end
            TAIL1: begin
                if (byte_hs) begin
                    if (bus.data_i == Tail1) begin
                        ok_d    = 1'b1;
                        state_d = PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT0;
                    end
                end
            end
            HUNT0: begin
                if (byte_hs && bus.data_i == Tail0) state_d = HUNT1;
            end
            HUNT1: begin
                if (byte_hs) begin
                    if (bus.data_i == Tail1)      state_d = PAYLOAD;
                    else if (bus.data_i == Tail0) state_d = HUNT1;
                    else                          state_d = HUNT0;
                end
            end
            default: state_d = PAYLOAD;
        endcase
    end

    // Hold register and element counters; padding of the final byte is
    // dropped because the hold clears on the frame's last element
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sub_q        <= '0;
            elem_q       <= '0;
        end else if (byte_hs && in_payload) begin
            hold_q       <= bus.data_i;
            hold_valid_q <= 1'b1;
            sub_q        <= '0;
        end else if (elem_hs) begin
            if (sub_q == SubLast || elem_at_last) begin
                hold_valid_q <= 1'b0;
                sub_q        <= '0;
            end else begin
                sub_q <= sub_q + 1'b1;
            end
            elem_q <= elem_at_last ? '0 : elem_q + 1'b1;
        end
    end

    // Element index always lies within the byte-rounded payload
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(elem_q) < PayloadBytes * PackedNum);

endmodule
